// File: rtl/param_register_file_pkg.sv
// Shared definitions for the parameterised register file.
// Contents: default geometry constants, sweeper state encoding and a helper
// that locates a port's slice inside a packed multi-port bus.
package reg_file_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NUM_RD = 2;

  typedef enum logic [0:0] {
    RF_SWEEP = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  // LSB position of port 'port' in a packed bus of 'width'-bit fields.
  function automatic int unsigned port_lsb(input int unsigned port,
                                           input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/param_register_file_if.sv
// Bus bundle between the pipeline (master: writeback + operand fetch) and the
// register file (slave).
//   clear_i    : request a full clear sweep
//   we_i/wd_addr_i/wd_i : write port
//   rd_addr_i  : NUM_RD packed read addresses
//   rd_data_o  : NUM_RD packed read data
//   busy_o     : clear sweep in progress
//   wr_drop_o  : write requested while busy, discarded
interface param_register_file_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = RF_NUM_RD
);
  logic                     clear_i;
  logic                     we_i;
  logic [ADDR_W-1:0]        wd_addr_i;
  logic [DATA_W-1:0]        wd_i;
  logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
  logic [NUM_RD*DATA_W-1:0] rd_data_o;
  logic                     busy_o;
  logic                     wr_drop_o;

  modport master (
    output clear_i, we_i, wd_addr_i, wd_i, rd_addr_i,
    input  rd_data_o, busy_o, wr_drop_o
  );

  modport slave (
    input  clear_i, we_i, wd_addr_i, wd_i, rd_addr_i,
    output rd_data_o, busy_o, wr_drop_o
  );
endinterface

// File: rtl/param_register_file_clear_sweeper.sv
// rf_clear_sweeper: walks every register-file entry once, one per cycle,
// after reset and whenever a clear is requested from READY.
// Ports:
//   clk_i, reset_ni : clock, async active-low reset (restarts the sweep)
//   clear_i         : start a sweep (only honoured in READY)
//   busy_o          : sweep in progress
//   clr_en/clr_addr : zero the addressed entry this cycle
module rf_clear_sweeper
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              clear_i,
  output logic              busy_o,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [0:0] ST_SWEEP = RF_SWEEP;
  localparam logic [0:0] ST_READY = RF_READY;
  // DEPTH-1 is all ones since the address range is always full.
  localparam logic [ADDR_W-1:0] LAST = '1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= ST_SWEEP;
      cnt   <= '0;
    end else begin
      case (state)
        ST_SWEEP: begin
          // Counter parks on the last entry; it never wraps.
          if (cnt == LAST) state <= ST_READY;
          else             cnt   <= cnt + 1'b1;
        end
        ST_READY: begin
          if (clear_i) begin
            state <= ST_SWEEP;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_SWEEP;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy_o   = (state == ST_SWEEP);
  assign clr_en   = busy_o;
  assign clr_addr = cnt;

endmodule

// File: rtl/param_register_file.sv
// param_register_file: DEPTH x DATA_W register file, one synchronous write
// port, NUM_RD combinational read ports. Storage has no reset; it is zeroed
// by rf_clear_sweeper after reset and on clear requests.
// Ports:
//   clk_i, reset_ni : clock, async active-low reset
//   bus (slave)     : clear/write/read signals, busy_o, wr_drop_o
// Build option: PARAM_REGISTER_FILE_WRITE_BYPASS_EN adds write-first
// forwarding from the write port to matching read ports in READY.
module param_register_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  param_register_file_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              busy;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_zero;

  rf_clear_sweeper #(.ADDR_W(ADDR_W)) u_sweeper (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clear_i  (bus.clear_i),
    .busy_o   (busy),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  assign wr_zero       = (ZERO_REG != 0) && (bus.wd_addr_i == '0);
  assign bus.busy_o    = busy;
  assign bus.wr_drop_o = bus.we_i & busy;

  // clr_en is high exactly while busy, so the sweep also blocks writes,
  // including writes to entries it has already cleared.
  always_ff @(posedge clk_i) begin
    if (clr_en)                    mem[clr_addr]      <= '0;
    else if (bus.we_i && !wr_zero) mem[bus.wd_addr_i] <= bus.wd_i;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdata;

    assign ra = bus.rd_addr_i[port_lsb(k, ADDR_W) +: ADDR_W];

    always_comb begin
      rdata = mem[ra];
`ifdef PARAM_REGISTER_FILE_WRITE_BYPASS_EN
      if (bus.we_i && (bus.wd_addr_i == ra)) rdata = bus.wd_i;
`endif
      // Forcing last lets busy and the zero register override the bypass.
      if (busy || ((ZERO_REG != 0) && (ra == '0))) rdata = '0;
    end

    assign bus.rd_data_o[port_lsb(k, DATA_W) +: DATA_W] = rdata;
  end

endmodule
